// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Imported by the deserializer and its helpers.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 217;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_t;

  function automatic int cnt_width(input int clks);
    return $clog2(clks);
  endfunction

endpackage

// File: rtl/uart_bit_sync.sv
// Two-flop synchronizer for one asynchronous input bit.
// Reset value is a parameter so idle-high lines come up idle.
module uart_bit_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_deser.sv
// UART 8N1 receive deserializer, mid-bit sampling, 1-entry buffer.
// Flags framing (bad stop bit) and overrun (buffer full) errors.
import uart_pkg::*;

module uart_rx_deser #(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8
) (
  input  logic                 pll_clk,
  input  logic                 rst,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic                 frame_err,
  output logic                 overrun_err
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FLUSH   = CW'(2);
  localparam logic [BW-1:0] LAST    = BW'(DATA_BITS - 1);

  uart_rx_state_t state, state_nx;

  logic                 rxs;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 cnt_clr;
  logic                 shift_en;
  logic                 deliver;
  logic                 ferr;

  uart_bit_sync #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk(pll_clk),
    .rst(rst),
    .d  (rx_in),
    .q  (rxs)
  );

  always_ff @(posedge pll_clk or posedge rst) begin
    if (rst) state <= WAIT_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    cnt_clr  = 1'b0;
    shift_en = 1'b0;
    deliver  = 1'b0;
    ferr     = 1'b0;
    unique case (state)
      WAIT_IDLE: begin
        // let the reset value drain out of the synchronizer first
        if (rxs && cnt >= FLUSH) begin
          state_nx = IDLE;
          cnt_clr  = 1'b1;
        end
      end
      IDLE: begin
        if (!rxs) begin
          state_nx = START;
          cnt_clr  = 1'b1;
        end
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_clr  = 1'b1;
          state_nx = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == FULL_M1) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_idx == LAST) state_nx = STOP;
        end
      end
      STOP: begin
        if (cnt == FULL_M1) begin
          cnt_clr = 1'b1;
          if (rxs) begin
            deliver  = 1'b1;
            state_nx = IDLE;
          end else begin
            ferr     = 1'b1;
            state_nx = WAIT_IDLE;
          end
        end
      end
      default: state_nx = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge pll_clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      cnt <= cnt_clr ? '0 : cnt + CW'(1);
      if (shift_en) begin
        shreg   <= {rxs, shreg[DATA_BITS-1:1]};
        bit_idx <= bit_idx + BW'(1);
      end else if (state != DATA) begin
        bit_idx <= '0;
      end
    end
  end

  // single-entry buffer: a full, unread slot keeps the older byte
  always_ff @(posedge pll_clk or posedge rst) begin
    if (rst) begin
      data_out    <= '0;
      valid_out   <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= ferr;
      overrun_err <= deliver && valid_out && !ready_in;
      if (deliver && (!valid_out || ready_in)) begin
        data_out  <= shreg;
        valid_out <= 1'b1;
      end else if (valid_out && ready_in) begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deser.sv
// Bench for uart_rx_deser: vector table, corner sequences,
// and random frames against a frame-level reference queue.
module tb_uart_rx_deser;

  localparam int C = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_in = 1'b1;
  logic       ready_in = 1'b1;
  logic [7:0] data_out;
  logic       valid_out;
  logic       frame_err;
  logic       overrun_err;

  int total = 0;
  int passed = 0;
  int cyc = 0;

  logic [7:0] got[$];
  int vcyc, vfall, ferr_n, ovr_n, rise_cyc;
  logic valid_q = 1'b0;

  typedef struct {
    logic [7:0] data;
    bit         stop;
    int         exp_bytes;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[6];

  uart_rx_deser #(
    .CLKS_PER_BIT(C),
    .DATA_BITS   (8)
  ) dut (
    .pll_clk    (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .frame_err  (frame_err),
    .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (valid_out && ready_in) got.push_back(data_out);
      if (valid_out) vcyc++;
      if (valid_out && !valid_q) rise_cyc = cyc;
      if (!valid_out && valid_q) vfall++;
      if (frame_err) ferr_n++;
      if (overrun_err) ovr_n++;
    end
    valid_q = valid_out;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear();
    got.delete();
    vcyc = 0;
    vfall = 0;
    ferr_n = 0;
    ovr_n = 0;
    rise_cyc = -1;
  endtask

  task automatic send(input logic [7:0] b, input bit stop);
    rx_in = 1'b0;
    tick(C);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      tick(C);
    end
    rx_in = stop;
    tick(C);
  endtask

  initial begin : main
    int base;
    logic [7:0] exp_q[$];
    int exp_ferr;
    logic [7:0] b;
    bit bad;
    logic [7:0] p;

    vecs[0] = '{8'h00, 1'b1, 1, 0};
    vecs[1] = '{8'hFF, 1'b1, 1, 0};
    vecs[2] = '{8'h80, 1'b1, 1, 0};
    vecs[3] = '{8'h01, 1'b1, 1, 0};
    vecs[4] = '{8'h33, 1'b0, 0, 1};
    vecs[5] = '{8'hC6, 1'b1, 1, 0};

    clear();
    tick(3);
    @(negedge clk);
    chk("reset data_out", data_out, 0);
    chk("reset valid_out", valid_out, 0);
    chk("reset frame_err", frame_err, 0);
    chk("reset overrun_err", overrun_err, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(20);

    // A5: latency and single-cycle valid
    clear();
    base = cyc;
    send(8'hA5, 1'b1);
    tick(2 * C);
    chk("a5 latency", rise_cyc - base, 1 + 2 + C / 2 + 9 * C);
    chk("a5 valid cycles", vcyc, 1);
    chk("a5 count", got.size(), 1);
    if (got.size() > 0) chk("a5 data", got[0], 8'hA5);
    chk("a5 ferr", ferr_n, 0);
    chk("a5 ovr", ovr_n, 0);

    for (int i = 0; i < 6; i++) begin
      clear();
      send(vecs[i].data, vecs[i].stop);
      rx_in = 1'b1;
      tick(2 * C);
      chk($sformatf("vec%0d count", i), got.size(), vecs[i].exp_bytes);
      if (vecs[i].exp_bytes > 0 && got.size() > 0)
        chk($sformatf("vec%0d data", i), got[0], vecs[i].data);
      chk($sformatf("vec%0d ferr", i), ferr_n, vecs[i].exp_ferr);
    end

    // short low glitch, then a real frame
    clear();
    rx_in = 1'b0;
    tick(3);
    rx_in = 1'b1;
    tick(2 * C);
    chk("glitch valid", vcyc, 0);
    chk("glitch ferr", ferr_n, 0);
    send(8'h3C, 1'b1);
    tick(2 * C);
    chk("post-glitch count", got.size(), 1);
    if (got.size() > 0) chk("post-glitch data", got[0], 8'h3C);

    // break: bad stop, line held low, then recovery
    clear();
    send(8'h55, 1'b0);
    tick(40 * C);
    rx_in = 1'b1;
    tick(C);
    send(8'h0F, 1'b1);
    tick(2 * C);
    chk("break ferr", ferr_n, 1);
    chk("break count", got.size(), 1);
    if (got.size() > 0) chk("break data", got[0], 8'h0F);

    // overrun with consumer stalled
    clear();
    ready_in = 1'b0;
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    tick(C);
    chk("ovr pulses", ovr_n, 1);
    chk("ovr valid held", valid_out, 1);
    chk("ovr data held", data_out, 8'h11);
    chk("ovr no handshake", got.size(), 0);
    ready_in = 1'b1;
    tick(4);
    chk("ovr drain count", got.size(), 1);
    if (got.size() > 0) chk("ovr drain data", got[0], 8'h11);
    chk("ovr valid drop", valid_out, 0);

    // ready pulsed exactly in each delivery cycle
    clear();
    ready_in = 1'b0;
    base = cyc;
    fork
      begin
        send(8'h01, 1'b1);
        send(8'h02, 1'b1);
        send(8'h03, 1'b1);
      end
      begin
        for (int k = 1; k < 3; k++) begin
          wait (cyc == base + 10 * C * k + 2 + C / 2 + 9 * C);
          #1;
          ready_in = 1'b1;
          @(posedge clk);
          #1;
          ready_in = 1'b0;
        end
      end
    join
    tick(2 * C);
    chk("stream ovr", ovr_n, 0);
    chk("stream valid falls", vfall, 0);
    chk("stream valid", valid_out, 1);
    chk("stream held data", data_out, 8'h03);
    ready_in = 1'b1;
    tick(3);
    chk("stream count", got.size(), 3);
    for (int i = 0; i < 3 && i < got.size(); i++)
      chk($sformatf("stream byte%0d", i), got[i], i + 1);

    // reset mid-frame with a byte buffered
    clear();
    ready_in = 1'b0;
    send(8'h5A, 1'b1);
    tick(C);
    p = 8'h96;
    rx_in = 1'b0;
    tick(C);
    for (int i = 0; i < 4; i++) begin
      rx_in = p[i];
      tick(C);
    end
    rx_in = p[4];
    tick(C / 2);
    rst = 1'b1;
    rx_in = 1'b0;
    @(negedge clk);
    chk("midrst data_out", data_out, 0);
    chk("midrst valid_out", valid_out, 0);
    chk("midrst frame_err", frame_err, 0);
    chk("midrst overrun_err", overrun_err, 0);
    @(posedge clk);
    #1;
    tick(3);
    rst = 1'b0;
    tick(5 * C);
    rx_in = 1'b1;
    tick(C);
    ready_in = 1'b1;
    send(8'h81, 1'b1);
    tick(2 * C);
    chk("midrst count", got.size(), 1);
    if (got.size() > 0) chk("midrst data", got[0], 8'h81);
    chk("midrst ferr", ferr_n, 0);
    chk("midrst ovr", ovr_n, 0);

    // random frames vs. frame-level model
    clear();
    exp_ferr = 0;
    for (int i = 0; i < 40; i++) begin
      b = 8'($urandom);
      bad = ($urandom_range(0, 4) == 0);
      send(b, !bad);
      if (bad) begin
        exp_ferr++;
        rx_in = 1'b1;
        tick(3 + $urandom_range(0, 10));
      end else begin
        exp_q.push_back(b);
        tick($urandom_range(0, 10));
      end
    end
    tick(2 * C);
    chk("rand count", got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("rand byte%0d", i), got[i], exp_q[i]);
    chk("rand ferr", ferr_n, exp_ferr);
    chk("rand ovr", ovr_n, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
